// File: rtl/pll_reconfig_seq_pkg.sv
// Shared types and encodings for the PLL counter reconfiguration sequencer.
// Holds the FSM state set plus the altpll_reconfig counter-type and parameter codes.
package pll_reconfig_pkg;

   typedef enum logic [2:0] {
      S_RST_PLL,
      S_RST_REC,
      S_IDLE,
      S_SETUP,
      S_WRITE,
      S_WAIT_BUSY,
      S_RECONFIG,
      S_WAIT_DONE
   } state_t;

   localparam logic [2:0] P_HIGH   = 3'b000;
   localparam logic [2:0] P_LOW    = 3'b001;
   localparam logic [2:0] P_BYPASS = 3'b100;
   localparam logic [2:0] P_ODD    = 3'b101;

   localparam logic [3:0] T_N  = 4'b0000;
   localparam logic [3:0] T_M  = 4'b0001;
   localparam logic [3:0] T_C0 = 4'b0100;

   // Channel 0 is M, channel 1 is N, channel k>=2 is post-scale counter C(k-2).
   function automatic logic [3:0] ch_type(input logic [2:0] ch);
      case (ch)
         3'd0:    return T_M;
         3'd1:    return T_N;
         default: return T_C0 + {1'b0, ch} - 4'd2;
      endcase
   endfunction

   function automatic logic [2:0] item_param(input logic [1:0] item);
      case (item)
         2'd0:    return P_HIGH;
         2'd1:    return P_LOW;
         2'd2:    return P_BYPASS;
         default: return P_ODD;
      endcase
   endfunction

endpackage

// File: rtl/pll_reconfig_seq_if.sv
// Scan-side connection between the sequencer and the altpll_reconfig megafunction.
interface pll_reconfig_seq_if #(
   parameter int FW = 8
);
   logic [3:0]  counter_type_ctr;
   logic [2:0]  counter_param_ctr;
   logic [FW:0] config_data_in;
   logic        write_param_ctr;
   logic        reconfig_ctr;
   logic        reset_ctr;
   logic        busy_ctr;

   modport master (
      output counter_type_ctr, counter_param_ctr, config_data_in,
      output write_param_ctr, reconfig_ctr, reset_ctr,
      input  busy_ctr
   );

   modport slave (
      input  counter_type_ctr, counter_param_ctr, config_data_in,
      input  write_param_ctr, reconfig_ctr, reset_ctr,
      output busy_ctr
   );
endinterface

// File: rtl/pll_reconfig_seq_div_split.sv
// Splits a division factor into altpll high/low counts plus bypass and odd flags.
module pll_div_split #(
   parameter int FW = 8
) (
   input  logic [FW-1:0] i_f,
   output logic [FW:0]   o_high,
   output logic [FW:0]   o_low,
   output logic          o_bypass,
   output logic          o_odd
);

   // NOTE: every output is assigned on every path, so no latch can be inferred.
   always_comb begin
      o_bypass = (i_f <= FW'(1));
      o_odd    = i_f[0];
      if (o_bypass) begin
         // A bypassed counter still needs legal non-zero counts loaded.
         o_high = (FW+1)'(1);
         o_low  = (FW+1)'(1);
      end else begin
         o_low  = {1'b0, i_f} >> 1;
         o_high = o_low + {{FW{1'b0}}, i_f[0]};
      end
   end

endmodule

// File: rtl/pll_reconfig_seq.sv
// Programs NUM_CH PLL counters through the altpll_reconfig scan port, then issues reconfig.
module pll_reconfig_seq
   import pll_reconfig_pkg::*;
#(
   parameter int NUM_CH      = 3,
   parameter int FW          = 8,
   parameter int SETUP_CYC   = 4,
   parameter int RST_CYC     = 10,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                 clock_ctr,
   input  logic                 sys_reset_n,
   input  logic                 trigger,
   input  logic [NUM_CH*FW-1:0] factors,
   pll_reconfig_seq_if.master   scan,
   output logic                 pll_areset_in_ctr,
   output logic                 pll_pfdena,
   output logic                 idle_state,
   output logic                 done,
   output logic                 timeout_err
);

   localparam int MAX_A = (RST_CYC > SETUP_CYC) ? RST_CYC : SETUP_CYC;
   localparam int MAX_C = (MAX_A > TIMEOUT_CYC) ? MAX_A : TIMEOUT_CYC;
   localparam int CW    = $clog2(MAX_C + 1);

   state_t               r_state;
   logic [CW-1:0]        r_cnt;
   logic [2:0]           r_ch;
   logic [1:0]           r_item;
   logic [NUM_CH*FW-1:0] r_shadow;
   logic [3:0]           r_type;
   logic [2:0]           r_param;
   logic [FW:0]          r_data;
   logic                 r_write, r_reconfig, r_reset_ctr;
   logic                 r_areset, r_idle, r_done, r_timeout;

   logic [FW-1:0] w_f;
   logic [FW:0]   w_high, w_low, w_data;
   logic          w_bypass, w_odd, w_last_ch, w_busy_clear;

   always_comb begin
      w_f = '0;
      for (int k = 0; k < NUM_CH; k++)
         if (r_ch == 3'(k)) w_f = r_shadow[k*FW +: FW];
   end

   pll_div_split #(.FW(FW)) u_split (
      .i_f      (w_f),
      .o_high   (w_high),
      .o_low    (w_low),
      .o_bypass (w_bypass),
      .o_odd    (w_odd)
   );

   always_comb begin
      case (r_item)
         2'd0:    w_data = w_high;
         2'd1:    w_data = w_low;
         2'd2:    w_data = {{FW{1'b0}}, w_bypass};
         default: w_data = {{FW{1'b0}}, w_odd};
      endcase
   end

   assign w_last_ch    = (r_ch == 3'(NUM_CH - 1));
   // Busy from altpll_reconfig lags the strobe by a cycle, so the first wait cycle is ignored.
   assign w_busy_clear = (r_cnt != '0) && !scan.busy_ctr;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock_ctr or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         r_state     <= S_RST_PLL;
         r_cnt       <= '0;
         r_ch        <= '0;
         r_item      <= '0;
         // NOTE: the shadow is reset too, so an aborted sequence leaves no stale factors behind.
         r_shadow    <= '0;
         r_type      <= '0;
         r_param     <= '0;
         r_data      <= '0;
         r_write     <= 1'b0;
         r_reconfig  <= 1'b0;
         r_reset_ctr <= 1'b0;
         r_areset    <= 1'b1;
         r_idle      <= 1'b0;
         r_done      <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_write     <= 1'b0;
         r_reconfig  <= 1'b0;
         r_reset_ctr <= 1'b0;
         r_done      <= 1'b0;
         case (r_state)
            S_RST_PLL: begin
               if (r_cnt == CW'(RST_CYC - 1)) begin
                  r_areset    <= 1'b0;
                  r_reset_ctr <= 1'b1;
                  r_cnt       <= '0;
                  r_state     <= S_RST_REC;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_RST_REC: begin
               r_idle  <= 1'b1;
               r_state <= S_IDLE;
            end
            S_IDLE: begin
               if (trigger) begin
                  r_shadow  <= factors;
                  r_ch      <= '0;
                  r_item    <= '0;
                  r_timeout <= 1'b0;
                  r_idle    <= 1'b0;
                  r_cnt     <= '0;
                  r_state   <= S_SETUP;
               end
            end
            S_SETUP: begin
               r_type  <= ch_type(r_ch);
               r_param <= item_param(r_item);
               r_data  <= w_data;
               if (r_cnt == CW'(SETUP_CYC)) begin
                  r_write <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= S_WRITE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_WRITE: begin
               r_cnt   <= '0;
               r_state <= S_WAIT_BUSY;
            end
            S_RECONFIG: begin
               r_cnt   <= '0;
               r_state <= S_WAIT_DONE;
            end
            S_WAIT_BUSY, S_WAIT_DONE: begin
               r_cnt <= r_cnt + 1'b1;
               if (w_busy_clear) begin
                  r_cnt <= '0;
                  if (r_state == S_WAIT_DONE) begin
                     r_done  <= 1'b1;
                     r_idle  <= 1'b1;
                     r_state <= S_IDLE;
                  end else if (r_item != 2'd3) begin
                     r_item  <= r_item + 2'd1;
                     r_state <= S_SETUP;
                  end else if (!w_last_ch) begin
                     r_ch    <= r_ch + 3'd1;
                     r_item  <= '0;
                     r_state <= S_SETUP;
                  end else begin
                     r_reconfig <= 1'b1;
                     r_state    <= S_RECONFIG;
                  end
               end else if (r_cnt == CW'(TIMEOUT_CYC - 1)) begin
                  r_timeout <= 1'b1;
                  r_areset  <= 1'b1;
                  r_type    <= '0;
                  r_param   <= '0;
                  r_data    <= '0;
                  r_cnt     <= '0;
                  r_state   <= S_RST_PLL;
               end
            end
            default: begin
               r_areset <= 1'b1;
               r_cnt    <= '0;
               r_state  <= S_RST_PLL;
            end
         endcase
      end
   end

   assign scan.counter_type_ctr  = r_type;
   assign scan.counter_param_ctr = r_param;
   assign scan.config_data_in    = r_data;
   assign scan.write_param_ctr   = r_write;
   assign scan.reconfig_ctr      = r_reconfig;
   assign scan.reset_ctr         = r_reset_ctr;
   assign pll_areset_in_ctr      = r_areset;
   assign pll_pfdena             = 1'b1;
   assign idle_state             = r_idle;
   assign done                   = r_done;
   assign timeout_err            = r_timeout;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Directed bench: three-counter instance for sequencing, timeout and reset abort;
// seven-counter instance for the widest channel set.
module tb_pll_reconfig_seq;

   localparam int FW = 8;

   typedef struct packed {
      logic [3:0]  typ;
      logic [2:0]  prm;
      logic [FW:0] dat;
   } wr_t;

   typedef struct packed {
      logic [3*FW-1:0] factors;
      wr_t [11:0]      w;
   } run_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n;
   logic             trig_a, trig_b, hold_a;
   logic [3*FW-1:0]  fac_a;
   logic [7*FW-1:0]  fac_b;
   logic             mb_a = 1'b0, mb_b = 1'b0;
   int               bc_a = 0, bc_b = 0;
   logic             areset_a, pfd_a, idle_a, done_a, to_a;
   logic             areset_b, pfd_b, idle_b, done_b, to_b;

   int n_checks = 0;
   int n_err    = 0;

   pll_reconfig_seq_if #(.FW(FW)) if_a ();
   pll_reconfig_seq_if #(.FW(FW)) if_b ();

   assign if_a.busy_ctr = hold_a | mb_a;
   assign if_b.busy_ctr = mb_b;

   pll_reconfig_seq #(.NUM_CH(3), .FW(FW), .SETUP_CYC(4), .RST_CYC(10), .TIMEOUT_CYC(255)) dut_a (
      .clock_ctr         (clk),
      .sys_reset_n       (rst_n),
      .trigger           (trig_a),
      .factors           (fac_a),
      .scan              (if_a),
      .pll_areset_in_ctr (areset_a),
      .pll_pfdena        (pfd_a),
      .idle_state        (idle_a),
      .done              (done_a),
      .timeout_err       (to_a)
   );

   pll_reconfig_seq #(.NUM_CH(7), .FW(FW), .SETUP_CYC(4), .RST_CYC(10), .TIMEOUT_CYC(255)) dut_b (
      .clock_ctr         (clk),
      .sys_reset_n       (rst_n),
      .trigger           (trig_b),
      .factors           (fac_b),
      .scan              (if_b),
      .pll_areset_in_ctr (areset_b),
      .pll_pfdena        (pfd_b),
      .idle_state        (idle_b),
      .done              (done_b),
      .timeout_err       (to_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // altpll_reconfig stand-in: busy rises with each strobe and stays high for 3 cycles.
   always @(negedge clk) begin
      if (if_a.write_param_ctr === 1'b1 || if_a.reconfig_ctr === 1'b1) begin
         mb_a = 1'b1; bc_a = 3;
      end else if (bc_a > 0) begin
         bc_a--;
         if (bc_a == 0) mb_a = 1'b0;
      end
      if (if_b.write_param_ctr === 1'b1 || if_b.reconfig_ctr === 1'b1) begin
         mb_b = 1'b1; bc_b = 3;
      end else if (bc_b > 0) begin
         bc_b--;
         if (bc_b == 0) mb_b = 1'b0;
      end
   end

   wr_t  q_a[$], q_b[$];
   wr_t  prev_a, prev_b;
   int   stab_a = 0, stab_b = 0;
   int   rc_a = 0, rc_b = 0, rc_at_a = 0, rc_at_b = 0, dn_a = 0, dn_b = 0;

   always @(negedge clk) begin
      wr_t cur_a, cur_b;
      cur_a = {if_a.counter_type_ctr, if_a.counter_param_ctr, if_a.config_data_in};
      cur_b = {if_b.counter_type_ctr, if_b.counter_param_ctr, if_b.config_data_in};
      if (cur_a === prev_a) stab_a++; else stab_a = 0;
      if (cur_b === prev_b) stab_b++; else stab_b = 0;
      prev_a = cur_a;
      prev_b = cur_b;
      if (if_a.write_param_ctr === 1'b1) begin
         q_a.push_back(cur_a);
         check("a_stable_before_write", 32'(stab_a >= 4), 32'd1);
      end
      if (if_b.write_param_ctr === 1'b1) begin
         q_b.push_back(cur_b);
         check("b_stable_before_write", 32'(stab_b >= 4), 32'd1);
      end
      if (if_a.reconfig_ctr === 1'b1) begin rc_a++; rc_at_a = q_a.size(); end
      if (if_b.reconfig_ctr === 1'b1) begin rc_b++; rc_at_b = q_b.size(); end
      if (done_a === 1'b1) dn_a++;
      if (done_b === 1'b1) dn_b++;
   end

   function automatic wr_t mk(input int t, input int p, input int d);
      return {4'(t), 3'(p), 9'(d)};
   endfunction

   task automatic pulse_trig_a();
      trig_a = 1'b1;
      @(negedge clk);
      trig_a = 1'b0;
   endtask

   // Called on the negedge where RST_PLL has just been entered.
   task automatic wait_init_a(input string name);
      int n = 0;
      while (areset_a === 1'b1 && n < 50) begin n++; @(negedge clk); end
      check({name, "_areset_cycles"}, 32'(n), 32'd10);
      check({name, "_reset_ctr_high"}, 32'(if_a.reset_ctr), 32'd1);
      @(negedge clk);
      check({name, "_reset_ctr_low"}, 32'(if_a.reset_ctr), 32'd0);
      check({name, "_idle"}, 32'(idle_a), 32'd1);
   endtask

   task automatic wait_writes_a(input int k, input int bound);
      int seen = 0, n = 0;
      while (seen < k && n < bound) begin
         @(negedge clk);
         n++;
         if (if_a.write_param_ctr === 1'b1) seen++;
      end
      check("a_write_strobes_reached", 32'(seen), 32'(k));
   endtask

   task automatic wait_done_a(input string name);
      int n = 0;
      while (done_a !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
      check({name, "_done_seen"}, 32'(done_a), 32'd1);
      @(negedge clk);
      check({name, "_done_one_cycle"}, 32'(done_a), 32'd0);
      check({name, "_idle_after_done"}, 32'(idle_a), 32'd1);
   endtask

   task automatic check_run_a(input string name, input run_t r);
      check({name, "_write_count"}, 32'(q_a.size()), 32'd12);
      for (int i = 0; i < 12; i++)
         if (i < q_a.size())
            check($sformatf("%s_w%0d", name, i), 32'(q_a[i]), 32'(r.w[i]));
   endtask

   run_t       runs [2];
   logic [3:0] b_type [7];
   logic [2:0] b_prm  [4];
   logic [8:0] b_dat  [4];

   initial begin
      // Set 0: M=12, N=1, C0=5.  Set 1: M=3, N=0, C0=2.
      runs[0].factors = {8'd5, 8'd1, 8'd12};
      runs[0].w[0]  = mk(1, 0, 6); runs[0].w[1]  = mk(1, 1, 6);
      runs[0].w[2]  = mk(1, 4, 0); runs[0].w[3]  = mk(1, 5, 0);
      runs[0].w[4]  = mk(0, 0, 1); runs[0].w[5]  = mk(0, 1, 1);
      runs[0].w[6]  = mk(0, 4, 1); runs[0].w[7]  = mk(0, 5, 1);
      runs[0].w[8]  = mk(4, 0, 3); runs[0].w[9]  = mk(4, 1, 2);
      runs[0].w[10] = mk(4, 4, 0); runs[0].w[11] = mk(4, 5, 1);
      runs[1].factors = {8'd2, 8'd0, 8'd3};
      runs[1].w[0]  = mk(1, 0, 2); runs[1].w[1]  = mk(1, 1, 1);
      runs[1].w[2]  = mk(1, 4, 0); runs[1].w[3]  = mk(1, 5, 1);
      runs[1].w[4]  = mk(0, 0, 1); runs[1].w[5]  = mk(0, 1, 1);
      runs[1].w[6]  = mk(0, 4, 1); runs[1].w[7]  = mk(0, 5, 0);
      runs[1].w[8]  = mk(4, 0, 1); runs[1].w[9]  = mk(4, 1, 1);
      runs[1].w[10] = mk(4, 4, 0); runs[1].w[11] = mk(4, 5, 0);
      // Seven channels: M, N, C0..C4; every factor 255.
      b_type = '{4'b0001, 4'b0000, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000};
      b_prm  = '{3'b000, 3'b001, 3'b100, 3'b101};
      b_dat  = '{9'd128, 9'd127, 9'd0, 9'd1};

      rst_n = 1'b1; trig_a = 1'b0; trig_b = 1'b0; hold_a = 1'b0;
      fac_a = '0; fac_b = '0;
      #2 rst_n = 1'b0;
      #20;
      check("rst_areset", 32'(areset_a), 32'd1);
      check("rst_reset_ctr", 32'(if_a.reset_ctr), 32'd0);
      check("rst_write", 32'(if_a.write_param_ctr), 32'd0);
      check("rst_reconfig", 32'(if_a.reconfig_ctr), 32'd0);
      check("rst_idle", 32'(idle_a), 32'd0);
      check("rst_done", 32'(done_a), 32'd0);
      check("rst_timeout", 32'(to_a), 32'd0);
      check("rst_pfdena", 32'(pfd_a), 32'd1);
      check("rst_bus", 32'({if_a.counter_type_ctr, if_a.counter_param_ctr, if_a.config_data_in}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_init_a("init");
      check("init_b_idle", 32'(idle_b), 32'd1);

      // Normal three-channel sequence, with a stray trigger mid-run.
      fac_a = runs[0].factors;
      q_a.delete(); rc_a = 0; dn_a = 0;
      pulse_trig_a();
      check("run0_left_idle", 32'(idle_a), 32'd0);
      wait_writes_a(3, 200);
      fac_a = '1;
      pulse_trig_a();
      wait_done_a("run0");
      check_run_a("run0", runs[0]);
      check("run0_reconfig_count", 32'(rc_a), 32'd1);
      check("run0_reconfig_after_12", 32'(rc_at_a), 32'd12);
      check("run0_done_count", 32'(dn_a), 32'd1);
      check("run0_no_timeout", 32'(to_a), 32'd0);

      // busy stuck high after the 5th write.
      fac_a = runs[0].factors;
      q_a.delete(); rc_a = 0; dn_a = 0;
      pulse_trig_a();
      wait_writes_a(5, 200);
      hold_a = 1'b1;
      begin
         int n = 0;
         while (to_a !== 1'b1 && n < 400) begin @(negedge clk); n++; end
         check("to_latency_in_window", 32'(n >= 250 && n <= 260), 32'd1);
      end
      check("to_write_count", 32'(q_a.size()), 32'd5);
      check("to_no_reconfig", 32'(rc_a), 32'd0);
      check("to_no_done", 32'(dn_a), 32'd0);
      wait_init_a("to_reinit");
      hold_a = 1'b0;
      check("to_sticky", 32'(to_a), 32'd1);
      q_a.delete();
      pulse_trig_a();
      check("to_cleared_by_trigger", 32'(to_a), 32'd0);
      wait_done_a("run1");
      check_run_a("run1", runs[0]);

      // Reset asserted during the 7th write strobe.
      q_a.delete();
      pulse_trig_a();
      wait_writes_a(7, 300);
      rst_n = 1'b0;
      #1;
      check("mid_rst_write", 32'(if_a.write_param_ctr), 32'd0);
      check("mid_rst_areset", 32'(areset_a), 32'd1);
      check("mid_rst_idle", 32'(idle_a), 32'd0);
      check("mid_rst_bus", 32'({if_a.counter_type_ctr, if_a.counter_param_ctr, if_a.config_data_in}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_init_a("mid_rst");
      q_a.delete();
      repeat (20) @(negedge clk);
      check("mid_rst_no_resume", 32'(q_a.size()), 32'd0);
      fac_a = runs[1].factors;
      pulse_trig_a();
      wait_done_a("run2");
      check_run_a("run2", runs[1]);

      // Seven channels, all factors 255.
      fac_b = '1;
      q_b.delete(); rc_b = 0; dn_b = 0;
      trig_b = 1'b1;
      @(negedge clk);
      trig_b = 1'b0;
      begin
         int n = 0;
         while (done_b !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
         check("b_done_seen", 32'(done_b), 32'd1);
      end
      check("b_write_count", 32'(q_b.size()), 32'd28);
      for (int c = 0; c < 7; c++)
         for (int it = 0; it < 4; it++)
            if (c * 4 + it < q_b.size())
               check($sformatf("b_ch%0d_item%0d", c, it), 32'(q_b[c*4+it]),
                     32'({b_type[c], b_prm[it], b_dat[it]}));
      check("b_reconfig_after_28", 32'(rc_at_b), 32'd28);
      check("b_reconfig_count", 32'(rc_b), 32'd1);
      check("b_no_timeout", 32'(to_b), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
